score_controller: RTL and testbench

- Drives `score_1`/`score_2` for the game FSM, which reads them to detect game over.
- Watches the ball X position for goals while the game is in play and increments the correct player's score once per goal.
- Holds the ball in reset for a serve delay after each goal, then rearms.
- Sits beside the ball and pad controllers under the game top logic; clocked by the system clock and paced by `timing_tick`.

---
 rtl/score_controller.sv | 121 ++++++++++++
 tb/tb_score_controller.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/score_controller.sv
// Goal detector and score keeper for the pong game: counts one goal per ball
// exit, holds the ball for a serve delay, then waits for it to re-centre.
module score_controller #(
  parameter int X_LEFT_GOAL  = 8,
  parameter int X_RIGHT_GOAL = 1016,
  parameter int WIN_SCORE    = 5,
  parameter int HOLD_TICKS   = 60
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        timing_tick,
  input  logic [1:0]  state,
  input  logic [10:0] x_ball,
  output logic [4:0]  score_1,
  output logic [4:0]  score_2,
  output logic        goal_pulse,
  output logic        serve_dir,
  output logic        ball_reset
);

  typedef enum logic [1:0] {ARMED, HOLD, WAIT_CLEAR} fsm_e;

  localparam int          CNT_W    = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS + 1) : 1;
  localparam logic [1:0]  ST_MENU  = 2'b00;
  localparam logic [1:0]  ST_PLAY  = 2'b01;
  localparam logic [10:0] X_LEFT   = 11'(X_LEFT_GOAL);
  localparam logic [10:0] X_RIGHT  = 11'(X_RIGHT_GOAL);
  localparam logic [4:0]  WIN      = 5'(WIN_SCORE);
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_TICKS);

  fsm_e             fsm_q, fsm_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [4:0]       score_1_q, score_1_d;
  logic [4:0]       score_2_q, score_2_d;
  logic             goal_q, goal_d;
  logic             serve_q, serve_d;
  logic             ball_reset_q, ball_reset_d;

  logic play, left_goal, right_goal, ball_inside;

  assign play        = (state == ST_PLAY);
  assign left_goal   = (x_ball <= X_LEFT);
  assign right_goal  = (x_ball >= X_RIGHT);
  assign ball_inside = !left_goal && !right_goal;

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    fsm_d     = fsm_q;
    cnt_d     = cnt_q;
    score_1_d = score_1_q;
    score_2_d = score_2_q;
    serve_d   = serve_q;
    goal_d    = 1'b0;

    if (!play) begin
      fsm_d = ARMED;
      cnt_d = '0;
      if (state == ST_MENU) begin
        score_1_d = '0;
        score_2_d = '0;
      end
    end else begin
      unique case (fsm_q)
        ARMED: begin
          if (left_goal) begin
            if (score_2_q < WIN) score_2_d = score_2_q + 5'd1;
            serve_d = 1'b0;
            goal_d  = 1'b1;
            fsm_d   = HOLD;
            cnt_d   = HOLD_LOAD;
          end else if (right_goal) begin
            if (score_1_q < WIN) score_1_d = score_1_q + 5'd1;
            serve_d = 1'b1;
            goal_d  = 1'b1;
            fsm_d   = HOLD;
            cnt_d   = HOLD_LOAD;
          end
        end
        HOLD: begin
          if (cnt_q == '0)      fsm_d = WAIT_CLEAR;
          else if (timing_tick) cnt_d = cnt_q - 1'b1;
        end
        WAIT_CLEAR: begin
          if (ball_inside) fsm_d = ARMED;
        end
        default: fsm_d = ARMED;
      endcase
    end

    // Registered from the next state so ball_reset rises alongside goal_pulse.
    ball_reset_d = !play || (fsm_d != ARMED);
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q        <= ARMED;
      cnt_q        <= '0;
      score_1_q    <= '0;
      score_2_q    <= '0;
      goal_q       <= 1'b0;
      serve_q      <= 1'b0;
      ball_reset_q <= 1'b1;
    end else begin
      fsm_q        <= fsm_d;
      cnt_q        <= cnt_d;
      score_1_q    <= score_1_d;
      score_2_q    <= score_2_d;
      goal_q       <= goal_d;
      serve_q      <= serve_d;
      ball_reset_q <= ball_reset_d;
    end
  end

  assign score_1    = score_1_q;
  assign score_2    = score_2_q;
  assign goal_pulse = goal_q;
  assign serve_dir  = serve_q;
  assign ball_reset = ball_reset_q;

endmodule

// File: tb/tb_score_controller.sv
// Directed bench for score_controller with a short serve hold of 3 ticks.
module tb_score_controller;

  localparam logic [1:0] ST_MENU = 2'b00;
  localparam logic [1:0] ST_PLAY = 2'b01;
  localparam logic [1:0] ST_OVER = 2'b10;

  logic        clk = 1'b0;
  logic        rst;
  logic        timing_tick;
  logic [1:0]  state;
  logic [10:0] x_ball;
  logic [4:0]  score_1, score_2;
  logic        goal_pulse, serve_dir, ball_reset;

  int n_pass  = 0;
  int n_total = 0;

  score_controller #(
    .X_LEFT_GOAL (8),
    .X_RIGHT_GOAL(1016),
    .WIN_SCORE   (5),
    .HOLD_TICKS  (3)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .timing_tick(timing_tick),
    .state      (state),
    .x_ball     (x_ball),
    .score_1    (score_1),
    .score_2    (score_2),
    .goal_pulse (goal_pulse),
    .serve_dir  (serve_dir),
    .ball_reset (ball_reset)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Brings the ball back to centre and lets the 3-tick hold expire.
  task automatic recover();
    x_ball = 11'd512;
    timing_tick = 1'b1;
    repeat (3) step();
    timing_tick = 1'b0;
    repeat (2) step();
  endtask

  task automatic fresh_play();
    state = ST_MENU; x_ball = 11'd512;
    step();
    state = ST_PLAY;
    step();
  endtask

  task automatic test_reset();
    rst = 1'b1; state = ST_MENU; x_ball = 11'd512; timing_tick = 1'b0;
    repeat (2) step();
    n_total++; if (score_1 !== 5'd0)  $display("FAIL reset_score_1 got %0d exp 0", score_1); else n_pass++;
    n_total++; if (score_2 !== 5'd0)  $display("FAIL reset_score_2 got %0d exp 0", score_2); else n_pass++;
    n_total++; if (goal_pulse !== 1'b0) $display("FAIL reset_goal got %b exp 0", goal_pulse); else n_pass++;
    n_total++; if (serve_dir !== 1'b0)  $display("FAIL reset_serve got %b exp 0", serve_dir); else n_pass++;
    n_total++; if (ball_reset !== 1'b1) $display("FAIL reset_ball_reset got %b exp 1", ball_reset); else n_pass++;
    rst = 1'b0;
  endtask

  task automatic test_idle_play();
    bit goal_seen = 1'b0;
    state = ST_PLAY; x_ball = 11'd512;
    step();
    n_total++; if (ball_reset !== 1'b0) $display("FAIL idle_ball_reset got %b exp 0", ball_reset); else n_pass++;
    for (int i = 0; i < 20; i++) begin
      step();
      if (goal_pulse !== 1'b0) goal_seen = 1'b1;
    end
    n_total++; if (goal_seen !== 1'b0) $display("FAIL idle_goal_pulse got %b exp 0", goal_seen); else n_pass++;
    n_total++; if ({score_1, score_2} !== 10'd0) $display("FAIL idle_scores got %0d/%0d exp 0/0", score_1, score_2); else n_pass++;
  endtask

  task automatic test_left_goal_held();
    bit goal_seen = 1'b0;
    bit br_low    = 1'b0;
    x_ball = 11'd8;
    step();
    n_total++; if (score_2 !== 5'd1)    $display("FAIL left_score_2 got %0d exp 1", score_2); else n_pass++;
    n_total++; if (score_1 !== 5'd0)    $display("FAIL left_score_1 got %0d exp 0", score_1); else n_pass++;
    n_total++; if (goal_pulse !== 1'b1) $display("FAIL left_goal_pulse got %b exp 1", goal_pulse); else n_pass++;
    n_total++; if (serve_dir !== 1'b0)  $display("FAIL left_serve got %b exp 0", serve_dir); else n_pass++;
    n_total++; if (ball_reset !== 1'b1) $display("FAIL left_ball_reset got %b exp 1", ball_reset); else n_pass++;
    for (int i = 0; i < 200; i++) begin
      timing_tick = (i % 10 == 0);
      step();
      if (goal_pulse !== 1'b0) goal_seen = 1'b1;
      if (ball_reset !== 1'b1) br_low = 1'b1;
    end
    timing_tick = 1'b0;
    n_total++; if (goal_seen !== 1'b0) $display("FAIL held_goal_repeat got %b exp 0", goal_seen); else n_pass++;
    n_total++; if (br_low !== 1'b0)    $display("FAIL held_ball_reset_drop got %b exp 0", br_low); else n_pass++;
    n_total++; if (score_2 !== 5'd1)   $display("FAIL held_score_2 got %0d exp 1", score_2); else n_pass++;
    x_ball = 11'd512;
    step();
    n_total++; if (ball_reset !== 1'b0) $display("FAIL rearm_ball_reset got %b exp 0", ball_reset); else n_pass++;
  endtask

  task automatic test_hold_length();
    bit br_low = 1'b0;
    x_ball = 11'd1020;
    step();
    n_total++; if (score_1 !== 5'd1)    $display("FAIL right_score_1 got %0d exp 1", score_1); else n_pass++;
    n_total++; if (serve_dir !== 1'b1)  $display("FAIL right_serve got %b exp 1", serve_dir); else n_pass++;
    n_total++; if (goal_pulse !== 1'b1) $display("FAIL right_goal_pulse got %b exp 1", goal_pulse); else n_pass++;
    x_ball = 11'd512; timing_tick = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      if (ball_reset !== 1'b1) br_low = 1'b1;
    end
    timing_tick = 1'b0;
    n_total++; if (br_low !== 1'b0) $display("FAIL hold_early_release got %b exp 0", br_low); else n_pass++;
    step();
    n_total++; if (ball_reset !== 1'b1) $display("FAIL hold_wait_clear got %b exp 1", ball_reset); else n_pass++;
    step();
    n_total++; if (ball_reset !== 1'b0) $display("FAIL hold_release got %b exp 0", ball_reset); else n_pass++;
    n_total++; if (serve_dir !== 1'b1)  $display("FAIL serve_hold got %b exp 1", serve_dir); else n_pass++;
  endtask

  task automatic test_boundaries();
    x_ball = 11'd9;
    step();
    n_total++; if (goal_pulse !== 1'b0) $display("FAIL bound_x9 got %b exp 0", goal_pulse); else n_pass++;
    x_ball = 11'd1015;
    step();
    n_total++; if (goal_pulse !== 1'b0) $display("FAIL bound_x1015 got %b exp 0", goal_pulse); else n_pass++;
    x_ball = 11'd1016;
    step();
    n_total++; if (goal_pulse !== 1'b1) $display("FAIL bound_x1016 got %b exp 1", goal_pulse); else n_pass++;
    n_total++; if (score_1 !== 5'd2)    $display("FAIL bound_score_1 got %0d exp 2", score_1); else n_pass++;
    recover();
  endtask

  task automatic test_saturation();
    fresh_play();
    for (int k = 1; k <= 6; k++) begin
      logic [4:0] exp_s1;
      exp_s1 = (k > 5) ? 5'd5 : 5'(k);
      x_ball = 11'd1020;
      step();
      n_total++; if (goal_pulse !== 1'b1) $display("FAIL sat_goal_%0d got %b exp 1", k, goal_pulse); else n_pass++;
      n_total++; if (score_1 !== exp_s1)  $display("FAIL sat_score_1_%0d got %0d exp %0d", k, score_1, exp_s1); else n_pass++;
      recover();
    end
    n_total++; if (score_2 !== 5'd0) $display("FAIL sat_score_2 got %0d exp 0", score_2); else n_pass++;
  endtask

  task automatic test_menu_game_over();
    bit changed = 1'b0;
    fresh_play();
    repeat (3) begin x_ball = 11'd1020; step(); recover(); end
    repeat (2) begin x_ball = 11'd8;    step(); recover(); end
    n_total++; if ({score_1, score_2} !== {5'd3, 5'd2}) $display("FAIL pre_over_scores got %0d/%0d exp 3/2", score_1, score_2); else n_pass++;
    state = ST_OVER; x_ball = 11'd8;
    for (int i = 0; i < 5; i++) begin
      step();
      if ({score_1, score_2} !== {5'd3, 5'd2} || ball_reset !== 1'b1 || goal_pulse !== 1'b0) changed = 1'b1;
    end
    n_total++; if (changed !== 1'b0) $display("FAIL over_hold got %b exp 0", changed); else n_pass++;
    state = 2'b11;
    step();
    n_total++; if ({score_1, score_2} !== {5'd3, 5'd2}) $display("FAIL state3_scores got %0d/%0d exp 3/2", score_1, score_2); else n_pass++;
    state = ST_MENU;
    step();
    n_total++; if ({score_1, score_2} !== 10'd0) $display("FAIL menu_clear got %0d/%0d exp 0/0", score_1, score_2); else n_pass++;
    n_total++; if (ball_reset !== 1'b1) $display("FAIL menu_ball_reset got %b exp 1", ball_reset); else n_pass++;
  endtask

  task automatic test_leave_mid_hold();
    fresh_play();
    x_ball = 11'd8;
    step();
    state = ST_OVER;
    step();
    n_total++; if (score_2 !== 5'd1) $display("FAIL leave_score_2 got %0d exp 1", score_2); else n_pass++;
    state = ST_PLAY; x_ball = 11'd512;
    step();
    n_total++; if (ball_reset !== 1'b0) $display("FAIL leave_rearm got %b exp 0", ball_reset); else n_pass++;
  endtask

  task automatic test_rst_mid_hold();
    x_ball = 11'd1020;
    step();
    timing_tick = 1'b1; step();
    timing_tick = 1'b0; step();
    rst = 1'b1;
    step();
    n_total++; if ({score_1, score_2} !== 10'd0) $display("FAIL rst_scores got %0d/%0d exp 0/0", score_1, score_2); else n_pass++;
    n_total++; if (goal_pulse !== 1'b0) $display("FAIL rst_goal got %b exp 0", goal_pulse); else n_pass++;
    n_total++; if (ball_reset !== 1'b1) $display("FAIL rst_ball_reset got %b exp 1", ball_reset); else n_pass++;
    n_total++; if (serve_dir !== 1'b0)  $display("FAIL rst_serve got %b exp 0", serve_dir); else n_pass++;
    rst = 1'b0; x_ball = 11'd512;
    step();
    n_total++; if (ball_reset !== 1'b0) $display("FAIL rst_armed got %b exp 0", ball_reset); else n_pass++;
  endtask

  task automatic test_back_to_back();
    bit goal_seen = 1'b0;
    x_ball = 11'd8;
    step();
    n_total++; if (score_2 !== 5'd1) $display("FAIL b2b_score_2 got %0d exp 1", score_2); else n_pass++;
    x_ball = 11'd1020;
    for (int i = 0; i < 30; i++) begin
      timing_tick = (i % 5 == 0);
      step();
      if (goal_pulse !== 1'b0) goal_seen = 1'b1;
    end
    timing_tick = 1'b0;
    n_total++; if (goal_seen !== 1'b0)  $display("FAIL b2b_goal got %b exp 0", goal_seen); else n_pass++;
    n_total++; if (score_1 !== 5'd0)    $display("FAIL b2b_score_1 got %0d exp 0", score_1); else n_pass++;
    n_total++; if (ball_reset !== 1'b1) $display("FAIL b2b_wait_clear got %b exp 1", ball_reset); else n_pass++;
    recover();
    n_total++; if (ball_reset !== 1'b0) $display("FAIL b2b_rearm got %b exp 0", ball_reset); else n_pass++;
  endtask

  initial begin
    rst = 1'b1; timing_tick = 1'b0; state = ST_MENU; x_ball = 11'd512;
    test_reset();
    test_idle_play();
    test_left_goal_held();
    test_hold_length();
    test_boundaries();
    test_saturation();
    test_menu_game_over();
    test_leave_mid_hold();
    test_rst_mid_hold();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
